uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one UART transmitter and its baud-rate
//  generator between N_REQ byte producers (e.g. ALU result path, status/echo path).
//  Grants one requester at a time, loads the byte into the TX, gates the baud
//  generator enable around each frame, and enforces an inter-frame gap.
//  A watchdog aborts frames whose TX-done never arrives.
// PARAMETERS
//  N_REQ          3    number of requesters (2..8)
//  DATA_W         8    byte width
//  GAP_TICKS      2    baud ticks of idle line after each frame (0 = no gap)
//  TIMEOUT_TICKS  24   baud ticks allowed in BUSY before abort (>=11)
// PORTS
//  i_clk          in   1             system clock
//  i_rst_n        in   1             asynchronous reset, active low
//  i_req          in   N_REQ         per-requester byte-valid, held until o_ack
//  i_data         in   N_REQ*DATA_W  requester k byte at [k*DATA_W +: DATA_W]
//  o_ack          out  N_REQ         1-cycle pulse: requester k's byte accepted
//  o_baud_en      out  1             drives baud generator enable (valid input)
//  i_baud_tick    in   1             baud tick from generator (may stay high >1 clk)
//  o_tx_start     out  1             1-cycle start pulse to UART TX
//  o_tx_data      out  DATA_W        byte to TX, stable from GRANT until next GRANT
//  i_tx_done      in   1             TX frame complete (pulse or level)
//  o_busy         out  1             high in any state other than IDLE
//  o_grant_id     out  clog2(N_REQ)  index of current/last granted requester
//  o_timeout      out  1             1-cycle pulse when watchdog aborts a frame
// BEHAVIOUR
//  Reset (i_rst_n=0, async): state=IDLE; all outputs 0; rr pointer=N_REQ-1
//   (req0 has first priority); tick/gap/timeout counters 0; tick_d=0.
//  Tick edge: tick_d registers i_baud_tick; tick_ev = i_baud_tick & ~tick_d.
//   Only tick_ev counts; edges ignored while o_baud_en=0.
//  FSM (all registered):
//   IDLE : o_baud_en=0. If |i_req -> GRANT; winner = first set bit scanning
//          ptr+1, ptr+2 .. wrapping mod N_REQ. Latch id and byte.
//   GRANT: o_ack[id]=1 (1 cycle), o_tx_data=byte, o_grant_id=id, ptr<=id,
//          o_baud_en=1 -> START.
//   START: o_tx_start=1 (1 cycle); clear timeout counter -> BUSY.
//   BUSY : i_tx_done=1 -> GAP. Else count tick_ev; at TIMEOUT_TICKS: o_timeout
//          pulse, -> GAP. done and final timeout tick same cycle: done wins,
//          no o_timeout.
//   GAP  : GAP_TICKS==0 -> IDLE next cycle. Else count tick_ev; on GAP_TICKS-th
//          -> IDLE. o_baud_en drops on entry to IDLE (generator resets count).
//  o_baud_en=1 in GRANT, START, BUSY, GAP; o_busy = (state!=IDLE).
//  Latency: i_req sampled high in IDLE at cycle n -> o_ack at n+1,
//   o_tx_start at n+2. Back-to-back requests re-arbitrate only from IDLE.
//  Requester dropping i_req before ack: withdrawn if not sampled in IDLE; once
//   latched, its byte is sent regardless.
//  i_tx_done in IDLE/GRANT/START/GAP ignored. i_req changes outside IDLE ignored.
//  Counters saturate-free: width clog2(max(GAP_TICKS,TIMEOUT_TICKS)+1), cleared
//   on each state entry.
//  Reset mid-frame: immediate return to reset state; in-flight byte dropped,
//   no o_ack/o_timeout generated.
// TESTING
//  1 i_req=3'b001, data0=8'hA5 -> o_ack=001 at n+1, o_tx_start+o_tx_data=A5 at
//    n+2; i_tx_done after 10 tick_ev -> GAP 2 ticks -> IDLE, o_baud_en=0.
//  2 i_req=3'b111 held, tx_done each frame -> grant order 0,1,2,0; each ack 1 cycle.
//  3 i_baud_tick held high 16 clocks per tick -> each tick counted once (gap=2 ticks).
//  4 no i_tx_done -> o_timeout pulse after 24 tick_ev, state returns IDLE, next
//    requester granted.
//  5 i_tx_done on same cycle as 24th tick_ev -> no o_timeout, normal GAP.
//  6 i_rst_n low during BUSY -> all outputs 0 async, ptr reset; req0 granted first after.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler: round-robin sharing of one UART TX and its baud generator among N_REQ byte producers
module uart_tx_scheduler #(
   parameter int N_REQ         = 3,
   parameter int DATA_W        = 8,
   parameter int GAP_TICKS     = 2,
   parameter int TIMEOUT_TICKS = 24
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*DATA_W-1:0]  i_data,
   output logic [N_REQ-1:0]         o_ack,
   output logic                     o_baud_en,
   input  logic                     i_baud_tick,
   output logic                     o_tx_start,
   output logic [DATA_W-1:0]        o_tx_data,
   input  logic                     i_tx_done,
   output logic                     o_busy,
   output logic [$clog2(N_REQ)-1:0] o_grant_id,
   output logic                     o_timeout
);
   localparam int IW = $clog2(N_REQ);
   localparam int CMAX = GAP_TICKS > TIMEOUT_TICKS ? GAP_TICKS : TIMEOUT_TICKS;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS == 0 ? 0 : GAP_TICKS - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_TICKS - 1);
   typedef enum logic [2:0] {IDLE, GRANT, START, BUSY, GAP} state_t;
   state_t state;
   logic [IW-1:0] ptr, win, idx;
   logic [CW-1:0] cnt;
   logic tick_d, tick_ev;
   assign tick_ev = i_baud_tick & ~tick_d;
   assign o_baud_en = o_busy;
   // scan from farthest to nearest so the requester just after ptr wins
   always_comb begin
      win = ptr;
      idx = ptr;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = IW'((int'(ptr) + i) % N_REQ);
         if (i_req[idx]) win = idx;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         ptr <= IW'(N_REQ - 1);
         cnt <= '0;
         tick_d <= 1'b0;
         o_ack <= '0;
         o_busy <= 1'b0;
         o_tx_start <= 1'b0;
         o_tx_data <= '0;
         o_grant_id <= '0;
         o_timeout <= 1'b0;
      end else begin
         tick_d <= i_baud_tick;
         o_ack <= '0;
         o_tx_start <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: if (|i_req) begin
               state <= GRANT;
               o_ack[win] <= 1'b1;
               o_tx_data <= i_data[win*DATA_W +: DATA_W];
               o_grant_id <= win;
               ptr <= win;
               o_busy <= 1'b1;
            end
            GRANT: begin
               state <= START;
               o_tx_start <= 1'b1;
            end
            START: begin
               state <= BUSY;
               cnt <= '0;
            end
            BUSY: if (i_tx_done) begin
               state <= GAP;
               cnt <= '0;
            end else if (tick_ev) begin
               if (cnt == TO_LAST) begin
                  state <= GAP;
                  cnt <= '0;
                  o_timeout <= 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            GAP: if (GAP_TICKS == 0 || (tick_ev && cnt == GAP_LAST)) begin
               state <= IDLE;
               cnt <= '0;
               o_busy <= 1'b0;
            end else if (tick_ev) cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// tb_uart_tx_scheduler: randomized frames checked against a round-robin / tick-count reference model
module tb_uart_tx_scheduler;
   logic i_clk = 1'b0, i_rst_n = 1'b0, i_baud_tick = 1'b0, i_tx_done = 1'b0;
   logic [2:0] i_req = '0;
   logic [23:0] i_data = '0;
   logic [2:0] o_ack;
   logic o_baud_en, o_tx_start, o_busy, o_timeout;
   logic [7:0] o_tx_data;
   logic [1:0] o_grant_id;
   int errors = 0, checks = 0, to_cnt = 0, ack_cnt = 0, start_cnt = 0, ptr_m = 2, t0, a0;

   uart_tx_scheduler #(.N_REQ(3), .DATA_W(8), .GAP_TICKS(2), .TIMEOUT_TICKS(24)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data), .o_ack(o_ack),
      .o_baud_en(o_baud_en), .i_baud_tick(i_baud_tick), .o_tx_start(o_tx_start),
      .o_tx_data(o_tx_data), .i_tx_done(i_tx_done), .o_busy(o_busy),
      .o_grant_id(o_grant_id), .o_timeout(o_timeout));

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      to_cnt += int'(o_timeout);
      ack_cnt += $countones(o_ack);
      start_cnt += int'(o_tx_start);
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick(input int p, input logic [2:0] r);
      for (int i = 1; i <= 3; i++) if (r[(p + i) % 3]) return (p + i) % 3;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int h);
      i_baud_tick = 1'b1;
      repeat (h) @(negedge i_clk);
      i_baud_tick = 1'b0;
      @(negedge i_clk);
   endtask

   // mode 0: done after k ticks; 1: no done (watchdog); 2: done together with the final watchdog tick
   task automatic frame(input logic [2:0] req, input int mode, input int k, input int h);
      int id, f0, fa, fs;
      logic [7:0] b;
      id = pick(ptr_m, req);
      b = i_data[id*8 +: 8];
      f0 = to_cnt;
      fa = ack_cnt;
      fs = start_cnt;
      chk("idle_busy", o_busy, 0);
      i_req = req;
      @(negedge i_clk);
      i_req = '0;
      chk("ack", o_ack, 32'(1 << id));
      chk("grant_id", o_grant_id, id);
      chk("tx_data", o_tx_data, b);
      chk("baud_en_grant", o_baud_en, 1);
      chk("start_early", o_tx_start, 0);
      @(negedge i_clk);
      chk("tx_start", o_tx_start, 1);
      chk("ack_width", o_ack, 0);
      @(negedge i_clk);
      chk("busy", o_busy, 1);
      i_req = 3'($urandom);
      if (mode == 0) begin
         repeat (k) tick(h);
         i_req = '0;
         i_tx_done = 1'b1;
         @(negedge i_clk);
         i_tx_done = 1'b0;
      end else begin
         repeat (23) tick(h);
         i_req = '0;
         chk("no_early_timeout", to_cnt - f0, 0);
         i_tx_done = (mode == 2);
         tick(h);
         i_tx_done = 1'b0;
      end
      chk("timeout_pulses", to_cnt - f0, mode == 1 ? 1 : 0);
      chk("gap_busy", o_busy, 1);
      tick(h);
      chk("gap_mid", o_baud_en, 1);
      tick(h);
      chk("idle_after_gap", o_busy, 0);
      chk("baud_off", o_baud_en, 0);
      chk("ack_count", ack_cnt - fa, 1);
      chk("start_count", start_cnt - fs, 1);
      chk("tx_data_hold", o_tx_data, b);
      ptr_m = id;
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_baud", o_baud_en, 0);
      chk("rst_ack", o_ack, 0);
      chk("rst_start", o_tx_start, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_gid", o_grant_id, 0);
      chk("rst_timeout", o_timeout, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      i_data = {16'($urandom), 8'hA5};
      frame(3'b001, 0, 10, 1);
      repeat (4) begin
         i_data = 24'($urandom);
         frame(3'b111, 0, 10, 1);
      end
      i_data = 24'($urandom);
      frame(3'b011, 0, 3, 16);
      i_data = 24'($urandom);
      frame(3'b110, 0, 2, 16);
      i_data = 24'($urandom);
      frame(3'b111, 1, 0, 1);
      i_data = 24'($urandom);
      frame(3'b111, 0, 4, 1);
      i_data = 24'($urandom);
      frame(3'b101, 2, 0, 2);
      repeat (10) begin
         i_data = 24'($urandom);
         frame(3'($urandom_range(1, 7)), $urandom_range(0, 2), $urandom_range(1, 23), $urandom_range(1, 4));
      end
      i_data = 24'($urandom);
      i_req = 3'b100;
      @(negedge i_clk);
      i_req = '0;
      repeat (2) @(negedge i_clk);
      tick(1);
      tick(1);
      t0 = to_cnt;
      a0 = ack_cnt;
      #2 i_rst_n = 1'b0;
      #1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_baud", o_baud_en, 0);
      chk("midrst_ack", o_ack, 0);
      chk("midrst_start", o_tx_start, 0);
      chk("midrst_data", o_tx_data, 0);
      chk("midrst_gid", o_grant_id, 0);
      chk("midrst_timeout", o_timeout, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      ptr_m = 2;
      @(negedge i_clk);
      chk("midrst_no_pulses", (to_cnt - t0) + (ack_cnt - a0), 0);
      i_data = 24'($urandom);
      frame(3'b111, 0, 5, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
